// File: rtl/axis_mux_sched.sv
// axis_mux_sched: frame-level round-robin scheduler for a 2:1 AXI-Stream mux.
// Holds each grant for HEIGHT lines, counted on output eol handshakes.
module axis_mux_sched #(
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned CNT_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic             in0_sof,
  input  logic             in1_valid,
  input  logic             in1_sof,
  input  logic             out_valid,
  input  logic             out_ready,
  input  logic             out_sof,
  input  logic             out_eol,
  output logic             select,
  output logic             enable,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_cnt,
  output logic             sof_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(HEIGHT - 1);

  logic [0:0]       state, state_nxt;
  logic             select_nxt, enable_nxt, frame_done_nxt, sof_err_nxt;
  logic             last, last_nxt, first, first_nxt;
  logic [CNT_W-1:0] line_cnt_nxt;
  logic             fire, req0, req1;

  assign fire = out_valid & out_ready;
  assign req0 = in0_valid & in0_sof;
  assign req1 = in1_valid & in1_sof;

  // Next-state and output decode
  always_comb begin
    state_nxt      = state;
    select_nxt     = select;
    enable_nxt     = enable;
    frame_done_nxt = 1'b0;
    line_cnt_nxt   = line_cnt;
    sof_err_nxt    = sof_err;
    last_nxt       = last;
    first_nxt      = first;

    // sof must appear on the first beat of a frame and nowhere else
    if (fire && (out_sof != first)) begin
      sof_err_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        enable_nxt = 1'b0;
        if (req0 || req1) begin
          select_nxt = (req0 && req1) ? ~last : req1;
          enable_nxt = 1'b1;
          first_nxt  = 1'b1;
          state_nxt  = LOCK;
        end
      end
      LOCK: begin
        if (fire) begin
          first_nxt = 1'b0;
          if (out_eol) begin
            if (line_cnt == LAST_LINE) begin
              line_cnt_nxt   = '0;
              last_nxt       = select;
              enable_nxt     = 1'b0;
              frame_done_nxt = 1'b1;
              state_nxt      = IDLE;
            end else begin
              line_cnt_nxt = line_cnt + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        enable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      select     <= 1'b0;
      enable     <= 1'b0;
      frame_done <= 1'b0;
      line_cnt   <= '0;
      sof_err    <= 1'b0;
      last       <= 1'b1;
      first      <= 1'b0;
    end else begin
      state      <= state_nxt;
      select     <= select_nxt;
      enable     <= enable_nxt;
      frame_done <= frame_done_nxt;
      line_cnt   <= line_cnt_nxt;
      sof_err    <= sof_err_nxt;
      last       <= last_nxt;
      first      <= first_nxt;
    end
  end

endmodule

// File: tb/tb_axis_mux_sched.sv
// Bench for axis_mux_sched: HEIGHT=1 vector table plus a HEIGHT=4 instance
// driven by two frame sources and checked against a frame-level model.
module tb_axis_mux_sched;

  localparam int H     = 4;
  localparam int BEATS = 3;
  localparam int CW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in0_valid, in0_sof, in1_valid, in1_sof;
  logic          out_valid, out_ready, out_sof, out_eol;
  logic          select, enable, frame_done, sof_err;
  logic [CW-1:0] line_cnt;

  logic       t_rst, t_i0v, t_i0s, t_i1v, t_i1s, t_ov, t_ordy, t_osof, t_oeol;
  logic       t_sel, t_en, t_fd, t_err;
  logic [0:0] t_cnt;

  axis_mux_sched #(.HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_sof(in0_sof), .in1_valid(in1_valid), .in1_sof(in1_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
    .select(select), .enable(enable), .frame_done(frame_done), .line_cnt(line_cnt),
    .sof_err(sof_err)
  );

  axis_mux_sched #(.HEIGHT(1)) dut1 (
    .clk(clk), .rst(t_rst),
    .in0_valid(t_i0v), .in0_sof(t_i0s), .in1_valid(t_i1v), .in1_sof(t_i1s),
    .out_valid(t_ov), .out_ready(t_ordy), .out_sof(t_osof), .out_eol(t_oeol),
    .select(t_sel), .enable(t_en), .frame_done(t_fd), .line_cnt(t_cnt),
    .sof_err(t_err)
  );

  typedef struct packed {
    logic rst, i0v, i0s, i1v, i1s;
    logic ov, ordy, osof, oeol;
    logic sel, en, fd, cnt, err;
  } vec_t;

  int checks = 0, failures = 0;

  // Sources: pend = a frame is queued, pos = next beat index within it
  bit pend[2];
  int pos[2], frames_left[2];
  int arr_pct, rdy_pct;
  bit inj_extra, inj_drop;

  // Frame-level reference model
  bit m_busy, m_sel, m_last, m_fd, m_err;
  int m_cnt, m_beats, m_frames;

  bit prev_en, prev_sel;
  int fd_seen;
  int grants[$];

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_last = 1; m_fd = 0; m_err = 0; m_cnt = 0; m_beats = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; pos[i] = 0; frames_left[i] = 0;
    end
  endtask

  task automatic drive();
    int s;
    in0_valid = pend[0]; in0_sof = pend[0] && pos[0] == 0;
    in1_valid = pend[1]; in1_sof = pend[1] && pos[1] == 0;
    out_ready = int'($urandom_range(99)) < rdy_pct;
    if (m_busy) begin
      s = m_sel ? 1 : 0;
      out_valid = pend[s];
      out_eol   = pend[s] && (pos[s] % BEATS == BEATS - 1);
      out_sof   = pend[s] && ((pos[s] == 0 && !inj_drop) || (inj_extra && pos[s] == 4));
    end else begin
      out_valid = 0; out_eol = 0; out_sof = 0;
    end
  endtask

  task automatic update();
    bit fire, r0, r1;
    int s;
    fire = out_valid && out_ready;
    r0 = in0_valid && in0_sof;
    r1 = in1_valid && in1_sof;
    if (rst) begin
      model_reset();
      return;
    end
    m_fd = 0;
    if (m_busy && fire && (out_sof != (m_beats == 0))) m_err = 1;
    if (!m_busy) begin
      if (r0 || r1) begin
        m_sel = (r0 && r1) ? !m_last : r1;
        m_busy = 1; m_beats = 0;
      end
    end else if (fire) begin
      s = m_sel ? 1 : 0;
      m_beats++;
      if (out_eol) m_cnt++;
      pos[s]++;
      if (pos[s] == H * BEATS) begin
        pend[s] = 0; pos[s] = 0;
      end
      if (m_cnt == H) begin
        m_cnt = 0; m_busy = 0; m_fd = 1; m_last = m_sel; m_frames++;
      end
    end
    for (int i = 0; i < 2; i++)
      if (!pend[i] && frames_left[i] > 0 && int'($urandom_range(99)) < arr_pct) begin
        pend[i] = 1; pos[i] = 0; frames_left[i]--;
      end
  endtask

  task automatic check(input string tag);
    logic [5:0] exp_v, act_v;
    exp_v = {m_sel, m_busy, m_fd, CW'(m_cnt), m_err};
    act_v = {select, enable, frame_done, line_cnt, sof_err};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t sel/en/fd/cnt/err got %b expected %b", tag, $time, act_v, exp_v);
    end
    if (prev_en && enable) begin
      checks++;
      if (select !== prev_sel) begin
        failures++;
        $display("FAIL %s_sel_stable t=%0t select got %b expected %b", tag, $time, select, prev_sel);
      end
    end
    if (!prev_en && enable) grants.push_back(int'(select));
    if (frame_done) fd_seen++;
    prev_en = enable; prev_sel = select;
  endtask

  task automatic expect_int(input string tag, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic step(input string tag);
    drive();
    @(posedge clk);
    update();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset();
    rst = 1;
    step("reset");
    rst = 0;
  endtask

  vec_t tv[14];
  int exp_g[4];

  initial begin
    // rst,i0v,i0s,i1v,i1s _ ov,ordy,osof,oeol _ exp sel,en,fd,cnt,err  (HEIGHT=1)
    tv[0]  = 14'b1_0000_0000_00000;
    tv[1]  = 14'b0_0000_0000_00000;
    tv[2]  = 14'b0_1111_0000_01000;
    tv[3]  = 14'b0_1111_1111_00100;
    tv[4]  = 14'b0_1111_0000_11000;
    tv[5]  = 14'b0_1111_1111_10100;
    tv[6]  = 14'b0_1111_0000_01000;
    tv[7]  = 14'b0_1111_1011_01000;
    tv[8]  = 14'b0_1111_1111_00100;
    tv[9]  = 14'b0_0011_0000_11000;
    tv[10] = 14'b0_0000_1101_10101;
    tv[11] = 14'b0_0000_0000_10001;
    tv[12] = 14'b1_0000_0000_00000;
    tv[13] = 14'b0_1111_0000_01000;

    rst = 1; in0_valid = 0; in0_sof = 0; in1_valid = 0; in1_sof = 0;
    out_valid = 0; out_ready = 0; out_sof = 0; out_eol = 0;
    inj_extra = 0; inj_drop = 0; arr_pct = 0; rdy_pct = 100;
    prev_en = 0; prev_sel = 0; fd_seen = 0; m_frames = 0;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      {t_rst, t_i0v, t_i0s, t_i1v, t_i1s, t_ov, t_ordy, t_osof, t_oeol} = tv[i][13:5];
      @(posedge clk);
      #1;
      checks++;
      if ({t_sel, t_en, t_fd, t_cnt, t_err} !== tv[i][4:0]) begin
        failures++;
        $display("FAIL h1_vec[%0d] sel/en/fd/cnt/err got %b expected %b",
                 i, {t_sel, t_en, t_fd, t_cnt, t_err}, tv[i][4:0]);
      end
    end

    // Single source, two frames
    do_reset();
    frames_left[0] = 2; arr_pct = 100; rdy_pct = 100; fd_seen = 0;
    run(50, "single");
    expect_int("single_frame_done_count", fd_seen, 2);

    // Both sources request together: grants must alternate starting with in0
    do_reset();
    grants.delete();
    frames_left[0] = 2; frames_left[1] = 2; arr_pct = 100;
    run(90, "rr");
    exp_g = '{0, 1, 0, 1};
    expect_int("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) expect_int("rr_grant_order", grants[i], exp_g[i]);

    // Random arrivals with 50% back-pressure
    do_reset();
    frames_left[0] = 8; frames_left[1] = 8; arr_pct = 20; rdy_pct = 50;
    fd_seen = 0; m_frames = 0;
    for (int c = 0; c < 3000 && m_frames < 16; c++) step("bp");
    expect_int("bp_frame_done_count", fd_seen, 16);

    // Extra sof on beat 5
    do_reset();
    rdy_pct = 100; arr_pct = 100; frames_left[0] = 1; inj_extra = 1;
    run(30, "err_extra");
    expect_int("err_extra_flag", int'(sof_err), 1);
    run(5, "err_extra_hold");
    expect_int("err_extra_sticky", int'(sof_err), 1);
    inj_extra = 0;

    // First beat missing sof
    do_reset();
    expect_int("err_cleared_by_reset", int'(sof_err), 0);
    arr_pct = 100; frames_left[1] = 1; inj_drop = 1;
    run(30, "err_drop");
    expect_int("err_drop_flag", int'(sof_err), 1);
    inj_drop = 0;

    // Asynchronous reset after two lines
    do_reset();
    arr_pct = 100; frames_left[0] = 1;
    for (int c = 0; c < 100 && m_cnt < 2; c++) step("pre_rst");
    expect_int("pre_rst_line_cnt", int'(line_cnt), 2);
    #2 rst = 1;
    #1;
    model_reset();
    check("rst_async");
    step("rst_hold");
    rst = 0;
    pend[1] = 1; pos[1] = 0; rdy_pct = 100;
    step("rst_regrant");
    expect_int("rst_regrant_select", int'(select), 1);
    expect_int("rst_regrant_enable", int'(enable), 1);
    run(20, "rst_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
